// File: rtl/iq_decimator.sv
// -----------------------------------------------------------------------------
// iq_decimator
//
// Accumulate-and-dump decimator for a signed I/Q sample stream. Every
// RATIO = 2**CNT_W accepted samples the per-channel sums are divided by RATIO
// (arithmetic shift) and presented on iout/qout together with a one-cycle
// out_valid strobe. The phase counter is exported so downstream logic can
// align to the same count convention as the transmit-side upsampler.
//
// Optional feature (compile-time macro DECIM_ROUND_EN):
//   defined   -> round-half-up: 2**(CNT_W-1) is added before the shift
//   undefined -> plain floor (truncating arithmetic shift), no rounding adder
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   qualifies iin/qin; state advances only when high
//   sync       phase realign: forces block phase to 0 (sample, if valid,
//              opens the new block)
//   iin, qin   signed IN_W input samples
//   iout, qout signed IN_W decimated outputs, registered, held between strobes
//   out_valid  one-cycle strobe, iout/qout are new this cycle
//   count      number of samples accumulated in the open block
// -----------------------------------------------------------------------------
module iq_decimator #(
    parameter int IN_W  = 4,
    parameter int CNT_W = 4,
    parameter int ACC_W = IN_W + CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    sync,
    input  logic signed [IN_W-1:0]  iin,
    input  logic signed [IN_W-1:0]  qin,
    output logic signed [IN_W-1:0]  iout,
    output logic signed [IN_W-1:0]  qout,
    output logic                    out_valid,
    output logic [CNT_W-1:0]        count
);

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

`ifdef DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(1'b1) <<< (CNT_W - 1);
`endif

    logic signed [ACC_W-1:0] acc_i_r, acc_q_r;
    logic signed [ACC_W-1:0] acc_i_nxt_s, acc_q_nxt_s;
    logic [CNT_W-1:0]        count_r, count_nxt_s;
    logic signed [IN_W-1:0]  iout_r, qout_r, iout_nxt_s, qout_nxt_s;
    logic                    out_valid_r, out_valid_nxt_s;

    logic signed [ACC_W-1:0] sext_i_s, sext_q_s;
    logic signed [ACC_W-1:0] sum_i_s, sum_q_s;
    logic signed [ACC_W-1:0] rnd_i_s, rnd_q_s;
    logic signed [ACC_W-1:0] sh_i_s, sh_q_s;

    // Datapath: sign extension, block sum, optional rounding and divide by RATIO.
    always_comb begin
        sext_i_s = ACC_W'(iin);
        sext_q_s = ACC_W'(qin);
        sum_i_s  = acc_i_r + sext_i_s;
        sum_q_s  = acc_q_r + sext_q_s;
`ifdef DECIM_ROUND_EN
        rnd_i_s  = sum_i_s + RND_C;
        rnd_q_s  = sum_q_s + RND_C;
`else
        rnd_i_s  = sum_i_s;
        rnd_q_s  = sum_q_s;
`endif
        // Accumulator width guarantees the quotient fits in IN_W bits.
        sh_i_s   = rnd_i_s >>> CNT_W;
        sh_q_s   = rnd_q_s >>> CNT_W;
    end

    // Next-state control: sync realign takes priority over accept/dump.
    always_comb begin
        acc_i_nxt_s     = acc_i_r;
        acc_q_nxt_s     = acc_q_r;
        count_nxt_s     = count_r;
        iout_nxt_s      = iout_r;
        qout_nxt_s      = qout_r;
        out_valid_nxt_s = 1'b0;
        if (sync) begin
            // A valid sample on the sync cycle opens the new block; any
            // pending dump is dropped.
            if (in_valid) begin
                acc_i_nxt_s = sext_i_s;
                acc_q_nxt_s = sext_q_s;
                count_nxt_s = CNT_W'(1'b1);
            end else begin
                acc_i_nxt_s = {ACC_W{1'b0}};
                acc_q_nxt_s = {ACC_W{1'b0}};
                count_nxt_s = {CNT_W{1'b0}};
            end
        end else if (in_valid) begin
            if (count_r == CNT_LAST) begin
                iout_nxt_s      = sh_i_s[IN_W-1:0];
                qout_nxt_s      = sh_q_s[IN_W-1:0];
                out_valid_nxt_s = 1'b1;
                acc_i_nxt_s     = {ACC_W{1'b0}};
                acc_q_nxt_s     = {ACC_W{1'b0}};
                count_nxt_s     = {CNT_W{1'b0}};
            end else begin
                acc_i_nxt_s = sum_i_s;
                acc_q_nxt_s = sum_q_s;
                count_nxt_s = count_r + CNT_W'(1'b1);
            end
        end else begin
            out_valid_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_i_r     <= {ACC_W{1'b0}};
            acc_q_r     <= {ACC_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            iout_r      <= {IN_W{1'b0}};
            qout_r      <= {IN_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            acc_i_r     <= acc_i_nxt_s;
            acc_q_r     <= acc_q_nxt_s;
            count_r     <= count_nxt_s;
            iout_r      <= iout_nxt_s;
            qout_r      <= qout_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    assign iout      = iout_r;
    assign qout      = qout_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;

endmodule

// File: tb/tb_iq_decimator.sv
// -----------------------------------------------------------------------------
// tb_iq_decimator
//
// Directed bench for iq_decimator. Expected averages are pushed to a
// scoreboard queue when the closing sample of a block is driven and popped
// when the DUT strobes out_valid. Between strobes the outputs must hold the
// last expected pair. Build with +define+DECIM_ROUND_EN to check the rounding
// variant.
// -----------------------------------------------------------------------------
module tb_iq_decimator;

    localparam int IN_W  = 4;
    localparam int CNT_W = 4;

    typedef struct {
        int i;
        int q;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   sync;
    logic signed [IN_W-1:0] iin;
    logic signed [IN_W-1:0] qin;
    logic signed [IN_W-1:0] iout;
    logic signed [IN_W-1:0] qout;
    logic                   out_valid;
    logic [CNT_W-1:0]       count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   last_i   = 0;
    int   last_q   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   strobe_cyc[$];

    always #5 clk = ~clk;

    iq_decimator #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .sync      (sync),
        .iin       (iin),
        .qin       (qin),
        .iout      (iout),
        .qout      (qout),
        .out_valid (out_valid),
        .count     (count)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ei, input int eq);
        exp_t e;
        e.i = ei;
        e.q = eq;
        sb.push_back(e);
    endtask

    // One clock: drive inputs, capture on the edge, check 1 time unit later.
    task automatic step(input logic v, input logic s, input int i, input int q,
                        input logic exp_sv, input int exp_cnt, input string tag);
        exp_t e;
        in_valid = v;
        sync     = s;
        iin      = IN_W'(i);
        qin      = IN_W'(q);
        @(posedge clk);
        #1;
        cyc++;
        check({tag, ".strobe"}, out_valid, exp_sv);
        check({tag, ".count"}, count, exp_cnt);
        if (out_valid === 1'b1) begin
            strobe_cyc.push_back(cyc);
            check({tag, ".sb_has_entry"}, (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, ".iout"}, iout, e.i);
                check({tag, ".qout"}, qout, e.q);
                last_i = e.i;
                last_q = e.q;
            end
        end else begin
            check({tag, ".iout_hold"}, iout, last_i);
            check({tag, ".qout_hold"}, qout, last_q);
        end
    endtask

    // A full block of 16 accepted samples starting from count 0.
    task automatic run_block(input int i_even, input int i_odd, input int q,
                             input int ei, input int eq, input string tag);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) push(ei, eq);
            step(1'b1, 1'b0, (k % 2 == 0) ? i_even : i_odd, q,
                 (k == 15), (k + 1) % 16, tag);
        end
    endtask

    initial begin
        int alt_exp;
`ifdef DECIM_ROUND_EN
        alt_exp = 0;
`else
        alt_exp = -1;
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        iin      = '0;
        qin      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.strobe", out_valid, 0);
        check("reset.count", count, 0);
        check("reset.iout", iout, 0);
        check("reset.qout", qout, 0);
        rst_n = 1'b1;

        // Basic block and the idle cycle after the strobe.
        run_block(3, 3, -1, 3, -1, "basic");
        step(1'b0, 1'b0, 5, 5, 1'b0, 0, "basic_idle");

        // Alternating extremes, sum -8: floor gives -1, rounding gives 0.
        run_block(7, -8, 0, alt_exp, 0, "alt");
        run_block(7, 7, -8, 7, -8, "max_i");
        run_block(-8, -8, 7, -8, 7, "min_i");

        // Accepted samples separated by random idle gaps.
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(1, 2)) begin
                int r;
                r = int'($urandom_range(0, 15));
                step(1'b0, 1'b0, r, r, 1'b0, k, "gap_idle");
            end
            if (k == 15) push(4, -3);
            step(1'b1, 1'b0, 4, -3, (k == 15), (k + 1) % 16, "gap");
        end

        // Sync mid-block at count 9 restarts the block with this sample.
        for (int k = 0; k < 9; k++)
            step(1'b1, 1'b0, 5, 5, 1'b0, k + 1, "pre_sync");
        step(1'b1, 1'b1, 2, 2, 1'b0, 1, "sync9");
        for (int k = 0; k < 15; k++) begin
            if (k == 14) push(2, 2);
            step(1'b1, 1'b0, 2, 2, (k == 14), (k + 2) % 16, "post_sync");
        end

        // Sync at count 15 overrides the dump; then sync alone clears.
        for (int k = 0; k < 15; k++)
            step(1'b1, 1'b0, 1, 1, 1'b0, k + 1, "pre_sync15");
        step(1'b1, 1'b1, 6, 6, 1'b0, 1, "sync15");
        step(1'b0, 1'b1, 6, 6, 1'b0, 0, "sync_idle");
        run_block(6, 6, -6, 6, -6, "after_sync");

        // Reset mid-block at count 7 drops the partial sum.
        for (int k = 0; k < 7; k++)
            step(1'b1, 1'b0, 3, 3, 1'b0, k + 1, "pre_rst");
        rst_n    = 1'b0;
        in_valid = 1'b1;
        iin      = 4'sd7;
        qin      = 4'sd7;
        @(posedge clk);
        #1;
        cyc++;
        check("midrst.strobe", out_valid, 0);
        check("midrst.count", count, 0);
        check("midrst.iout", iout, 0);
        check("midrst.qout", qout, 0);
        last_i = 0;
        last_q = 0;
        rst_n  = 1'b1;
        run_block(-5, -5, 5, -5, 5, "after_rst");

        // Continuous stream: four strobes 16 cycles apart.
        strobe_cyc.delete();
        for (int k = 0; k < 64; k++) begin
            if (k % 16 == 15) push(1, -2);
            step(1'b1, 1'b0, 1, -2, (k % 16 == 15), (k + 1) % 16, "stream");
        end
        check("stream.n_strobes", strobe_cyc.size(), 4);
        if (strobe_cyc.size() == 4) begin
            for (int j = 1; j < 4; j++)
                check("stream.spacing", strobe_cyc[j] - strobe_cyc[j-1], 16);
        end

        step(1'b0, 1'b0, 0, 0, 1'b0, 0, "final_idle");
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
